// File: rtl/sha3_pkg.sv
// Shared types and ASCII constants for the digest hex transmitter.
// HEX_CRLF_EN adds the CR/LF trailer states.
package sha3_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HEX
`ifdef HEX_CRLF_EN
    ,
    SEND_CR,
    SEND_LF
`endif
  } hex_tx_state_e;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational nibble to lowercase ASCII hex digit encoder.
module nibble_to_ascii
  import sha3_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_0 + {4'h0, nibble};
    else                ascii = ASCII_A_LC + {4'h0, nibble} - 8'd10;
  end

endmodule

// File: rtl/digest_hex_tx.sv
// Streams a captured digest to a UART as lowercase hex, MS nibble first.
// Define HEX_CRLF_EN to append CR LF after the hex characters.
module digest_hex_tx
  import sha3_pkg::*;
#(
  parameter int unsigned D = 512
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         digest_valid,
  input  logic [D-1:0] digest,
  input  logic         tx_busy,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned NIB = D / 4;
  localparam int unsigned CW  = $clog2(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  hex_tx_state_e state_q, state_d;
  logic [D-1:0]  digest_q;
  logic [CW-1:0] cnt_q;
  logic          done_q, done_d;
  logic          hex_accept;
  logic [7:0]    hex_char;

  assign hex_accept = (state_q == SEND_HEX) && !tx_busy;

  nibble_to_ascii u_enc (
    .nibble (digest_q[D-1 -: 4]),
    .ascii  (hex_char)
  );

  // The digest register shifts left so the outgoing nibble is always the top
  // one; it is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == IDLE && digest_valid) digest_q <= digest;
      else if (hex_accept)                 digest_q <= digest_q << 4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == IDLE && digest_valid)  cnt_q <= '0;
      else if (hex_accept && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (digest_valid) state_d = SEND_HEX;
      end
      SEND_HEX: begin
        tx_valid = 1'b1;
        tx_data  = hex_char;
        if (!tx_busy && cnt_q == LAST) begin
`ifdef HEX_CRLF_EN
          state_d = SEND_CR;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef HEX_CRLF_EN
      SEND_CR: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_CR;
        if (!tx_busy) state_d = SEND_LF;
      end
      SEND_LF: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
        if (!tx_busy) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_digest_hex_tx.sv
// Directed self-checking bench for digest_hex_tx at D=16 and D=512.
// Honours HEX_CRLF_EN for the expected character count.
module tb_digest_hex_tx;

`ifdef HEX_CRLF_EN
  localparam int NCH16  = 6;
  localparam int NCH512 = 130;
`else
  localparam int NCH16  = 4;
  localparam int NCH512 = 128;
`endif

  logic        clk = 1'b0;
  logic        r16, dv16, tb16;
  logic [15:0] dg16;
  logic [7:0]  td16;
  logic        tv16, bz16, dn16;

  logic         r512, dv512, tb512;
  logic [511:0] dg512;
  logic [7:0]   td512;
  logic         tv512, bz512, dn512;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digest_hex_tx #(.D(16)) u16 (
    .clk(clk), .reset(r16), .digest_valid(dv16), .digest(dg16), .tx_busy(tb16),
    .tx_data(td16), .tx_valid(tv16), .busy(bz16), .done(dn16)
  );

  digest_hex_tx #(.D(512)) u512 (
    .clk(clk), .reset(r512), .digest_valid(dv512), .digest(dg512), .tx_busy(tb512),
    .tx_data(td512), .tx_valid(tv512), .busy(bz512), .done(dn512)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(8'h30 + n) : 8'(8'h57 + n);
  endfunction

  task automatic start16(input logic [15:0] d);
    dg16 = d;
    dv16 = 1'b1;
    @(negedge clk);
    dv16 = 1'b0;
  endtask

  // ev[4], ev[5] are the CR/LF trailer, used only with HEX_CRLF_EN.
  task automatic body16(input string tag, input logic [7:0] ev [6],
                        input int stall_idx, input int inject_idx);
    for (int i = 0; i < NCH16; i++) begin
      dv16 = (i == inject_idx);
      if (i == inject_idx) dg16 = 16'h1234;
      if (i == stall_idx) begin
        tb16 = 1'b1;
        for (int s = 0; s < 5; s++) begin
          chkb({tag, "_stall_valid"}, tv16, 1'b1);
          chk({tag, "_stall_data"}, td16, ev[i]);
          @(negedge clk);
        end
        tb16 = 1'b0;
      end
      chkb({tag, "_valid"}, tv16, 1'b1);
      chk({tag, "_char"}, td16, ev[i]);
      chkb({tag, "_busy"}, bz16, 1'b1);
      chkb({tag, "_done_early"}, dn16, 1'b0);
      @(negedge clk);
    end
    dv16 = 1'b0;
    chkb({tag, "_done"}, dn16, 1'b1);
    chkb({tag, "_end_valid"}, tv16, 1'b0);
    chkb({tag, "_end_busy"}, bz16, 1'b0);
  endtask

  task automatic body512(input string tag, input int mode);
    logic [7:0] e;
    for (int i = 0; i < NCH512; i++) begin
      if (i == 128)      e = 8'h0D;
      else if (i == 129) e = 8'h0A;
      else if (mode == 0) e = 8'h30;
      else               e = hexc(i % 16);
      chkb({tag, "_valid"}, tv512, 1'b1);
      chk({tag, "_char"}, td512, e);
      chkb({tag, "_done_early"}, dn512, 1'b0);
      @(negedge clk);
    end
    chkb({tag, "_done"}, dn512, 1'b1);
    chkb({tag, "_end_valid"}, tv512, 1'b0);
    @(negedge clk);
    chkb({tag, "_done_pulse"}, dn512, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] pat;
    r16 = 1'b1; dv16 = 1'b0; tb16 = 1'b0; dg16 = '0;
    r512 = 1'b1; dv512 = 1'b0; tb512 = 1'b0; dg512 = '0;
    @(negedge clk);
    @(negedge clk);
    chkb("rst_valid", tv16, 1'b0);
    chkb("rst_busy", bz16, 1'b0);
    chkb("rst_done", dn16, 1'b0);
    chk("rst_data", td16, 8'h00);
    chk("rst_data512", td512, 8'h00);
    chkb("rst_valid512", tv512, 1'b0);
    r16 = 1'b0;
    r512 = 1'b0;
    @(negedge clk);

    // Basic vector 09af, mixed digits and letters
    start16(16'h09af);
    body16("v09af", '{8'h30, 8'h39, 8'h61, 8'h66, 8'h0D, 8'h0A}, -1, -1);
    @(negedge clk);
    chkb("v09af_done_pulse", dn16, 1'b0);

    // Five-cycle tx_busy stall on the third character
    start16(16'hfedc);
    body16("stall", '{8'h66, 8'h65, 8'h64, 8'h63, 8'h0D, 8'h0A}, 2, -1);
    @(negedge clk);

    // digest_valid with another digest during streaming is ignored
    start16(16'h5678);
    body16("ignore", '{8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A}, -1, 1);
    @(negedge clk);
    chkb("ignore_no_restart_valid", tv16, 1'b0);
    chkb("ignore_no_restart_busy", bz16, 1'b0);
    @(negedge clk);

    // Back-to-back: new digest_valid in the done cycle
    start16(16'ha5f0);
    body16("b2b_first", '{8'h61, 8'h35, 8'h66, 8'h30, 8'h0D, 8'h0A}, -1, -1);
    start16(16'h8e91);
    body16("b2b_second", '{8'h38, 8'h65, 8'h39, 8'h31, 8'h0D, 8'h0A}, -1, -1);
    @(negedge clk);

    // Reset after the third character is accepted
    start16(16'hb1e3);
    chk("rst_mid_c0", td16, 8'h62);
    @(negedge clk);
    chk("rst_mid_c1", td16, 8'h31);
    @(negedge clk);
    chk("rst_mid_c2", td16, 8'h65);
    @(negedge clk);
    chk("rst_mid_c3", td16, 8'h33);
    r16 = 1'b1;
    dv16 = 1'b1;
    dg16 = 16'hffff;
    @(negedge clk);
    r16 = 1'b0;
    dv16 = 1'b0;
    chkb("rst_mid_valid", tv16, 1'b0);
    chkb("rst_mid_busy", bz16, 1'b0);
    chkb("rst_mid_done", dn16, 1'b0);
    chk("rst_mid_data", td16, 8'h00);
    @(negedge clk);
    chkb("rst_mid_quiet", tv16, 1'b0);
    start16(16'h7c2d);
    body16("after_rst", '{8'h37, 8'h63, 8'h32, 8'h64, 8'h0D, 8'h0A}, -1, -1);
    @(negedge clk);

    // D=512 all-zero digest
    dg512 = '0;
    dv512 = 1'b1;
    @(negedge clk);
    dv512 = 1'b0;
    body512("zero512", 0);

    // D=512 repeating 0123...ef pattern checks MS-nibble-first ordering
    pat = '0;
    for (int k = 0; k < 8; k++) pat = {pat[447:0], 64'h0123456789abcdef};
    dg512 = pat;
    dv512 = 1'b1;
    @(negedge clk);
    dv512 = 1'b0;
    body512("pat512", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
